// File: rtl/popcount_stream_if.sv
// popcount_stream_if
//   Stream bundle for the pipelined population counter: an input word
//   stream (valid/ready/data/last) and a result stream (valid/ready plus the
//   per-word count, the saturating frame total, last and saturation flags).
//
//   Parameters
//     DATA_W : input word width (multiple of 4, at least 4)
//     ACC_W  : frame total width (at least CNT_W)
//     CNT_W  : per-word count width; leave at its default so that it matches
//              the counter, which derives the same value internally
//
//   Modports
//     master : the side that produces words and consumes results
//     slave  : the counter itself
interface popcount_stream_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = $clog2(DATA_W + 1)
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [ACC_W-1:0]  out_total;
  logic              out_last;
  logic              out_sat;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_count, out_total, out_last, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_count, out_total, out_last, out_sat
  );

endinterface

// File: rtl/popcount_stream.sv
// popcount_stream
//   Two-stage streaming population counter. Stage 1 registers a 0..4 count
//   for every nibble of the accepted word; stage 2 (the output register)
//   adds those nibble counts into the word count and folds it into a
//   per-frame running total that saturates at its maximum value.
//
//   Ports
//     clk   : rising-edge clock
//     rst   : synchronous active-high reset
//     clear : synchronous flush of pipeline and accumulator (same as rst)
//     bus   : popcount_stream_if.slave
//             in_valid/in_ready/in_data/in_last  - word stream in
//             out_valid/out_ready                - result handshake
//             out_count                          - ones in the word
//             out_total                          - saturating frame total
//             out_last                           - delayed in_last
//             out_sat                            - sticky frame saturation
module popcount_stream #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 16
) (
  input logic             clk,
  input logic             rst,
  input logic             clear,
  popcount_stream_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int NIB_N = DATA_W / 4;

  logic             flush;
  logic             en;
  logic             accept;

  logic [2:0]       nib_cnt [NIB_N];
  logic             v1;
  logic             last1;

  logic [CNT_W-1:0] word_cnt;
  logic [ACC_W:0]   base;
  logic [ACC_W:0]   sum;

  logic             out_valid_q;
  logic [CNT_W-1:0] out_count_q;
  logic [ACC_W-1:0] out_total_q;
  logic             out_last_q;
  logic             out_sat_q;
  logic             frame_start;

  function automatic logic [2:0] nib_pop(input logic [3:0] n);
    nib_pop = {2'b00, n[0]} + {2'b00, n[1]} + {2'b00, n[2]} + {2'b00, n[3]};
  endfunction

  // The whole pipeline advances together whenever the output register is
  // empty or being drained; a flush cycle never accepts a word.
  assign flush    = rst || clear;
  assign en       = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en && !flush;
  assign accept   = bus.in_valid && bus.in_ready;

  // Stage 1: per-nibble counts plus the valid/last sidebands. Loading on en
  // even without a word lets a bubble (v1 = 0) flow through.
  always_ff @(posedge clk) begin
    if (flush) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      for (int i = 0; i < NIB_N; i++) nib_cnt[i] <= 3'd0;
    end else if (en) begin
      v1    <= accept;
      last1 <= bus.in_last;
      for (int i = 0; i < NIB_N; i++) nib_cnt[i] <= nib_pop(bus.in_data[4*i +: 4]);
    end
  end

  // Word count and accumulator arithmetic. CNT_W holds DATA_W exactly, and
  // the sum is one bit wider than the total, so neither can wrap; the top
  // bit of sum is the saturation indication.
  always_comb begin
    word_cnt = '0;
    for (int i = 0; i < NIB_N; i++) word_cnt = word_cnt + CNT_W'(nib_cnt[i]);
    base = frame_start ? '0 : {1'b0, out_total_q};
    sum  = base + (ACC_W + 1)'(word_cnt);
  end

  // Stage 2 / output register. A load with last1 set marks the next load as
  // the first word of a new frame; saturation is sticky within a frame only.
  always_ff @(posedge clk) begin
    if (flush) begin
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_total_q <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      frame_start <= 1'b1;
    end else if (en) begin
      if (v1) begin
        out_valid_q <= 1'b1;
        out_count_q <= word_cnt;
        out_last_q  <= last1;
        frame_start <= last1;
        if (sum[ACC_W]) begin
          out_total_q <= '1;
          out_sat_q   <= 1'b1;
        end else begin
          out_total_q <= sum[ACC_W-1:0];
          out_sat_q   <= frame_start ? 1'b0 : out_sat_q;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.out_total = out_total_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sat   = out_sat_q;

endmodule
